counter_sequencer: RTL and testbench

- Run-control sequencer for the 3-bit JK-flip-flop up-counter datapath and its 7-segment display path.
- Replaces free-running counting with start/stop/step control, a prescaled count rate, and one-shot or wrap modes.
- Drives the counter's enable and clear, and watches the counter value `iQ` to detect the terminal count.
- Sits between the debounced board buttons and the counter; everything is clocked from the single board clock `CLK`.

---
 rtl/counter_seq_pkg.sv | 19 +
 rtl/seq_tick_gen.sv | 44 ++++
 rtl/counter_sequencer.sv | 134 +++++++++++++
 tb/tb_counter_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_pkg.sv
// State encoding and prescaler defaults shared by counter_sequencer and its tick generator.
package counter_seq_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } seq_state_e;

   localparam int DIV_DEFAULT = 50000000;
   localparam int DIV_BENCH   = 4;

   // Bits needed to hold a prescaler count of 0..div-1, never less than one.
   function automatic int cnt_width(input int div);
      return (div > 2) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/seq_tick_gen.sv
// Prescaler for counter_sequencer: emits a one-cycle oTick every DIV enabled cycles.
// Deasserting iEn returns the count to zero so each enabled stretch starts a fresh period.
module seq_tick_gen
   import counter_seq_pkg::*;
#(
   parameter int DIV = DIV_DEFAULT
) (
   input  logic CLK,
   input  logic RST,
   input  logic iEn,
   output logic oTick
);

   localparam int CW = cnt_width(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q, tick_d;

   always_comb begin
      cnt_d  = '0;
      tick_d = 1'b0;
      if (iEn) begin
         if (cnt_q == LAST) begin
            tick_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign oTick = tick_q;

endmodule

// File: rtl/counter_sequencer.sv
// Start/stop/step run control for the 3-bit up-counter, with one-shot or wrap modes.
// Define COUNTER_SEQ_AUTO_RESTART_EN to make DONE restart the run by itself after DIV cycles.
module counter_sequencer
   import counter_seq_pkg::*;
#(
   parameter int DIV   = DIV_DEFAULT,
   parameter int WIDTH = 3,
   parameter int TC    = 7
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             iStart,
   input  logic             iStop,
   input  logic             iStep,
   input  logic             iMode,
   input  logic [WIDTH-1:0] iQ,
   output logic             oEn,
   output logic             oClr,
   output logic             oTick,
   output logic [1:0]       oState,
   output logic             oDone
);

   localparam logic [WIDTH-1:0] LAST_Q = WIDTH'(TC - 1);

   seq_state_e state_q, state_d;
   logic [2:0] cmd_q, cmd_prev_q, cmd_rise;
   logic       clr_q, clr_d;
   logic       step_q, step_d;
   logic       done_q;
   logic       tick, tick_en, en;
   logic       stop_e, start_e, step_e, hit_tc;

   // Commands are packed {stop, start, step}.
   assign cmd_rise = cmd_q & ~cmd_prev_q;
   assign stop_e   = cmd_rise[2];
   assign start_e  = cmd_rise[1];
   assign step_e   = cmd_rise[0];

   assign en     = (tick && state_q == S_RUN) || step_q;
   assign hit_tc = en && !iMode && (iQ == LAST_Q);

   always_comb begin
      state_d = state_q;
      clr_d   = 1'b0;
      step_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (stop_e) begin
               state_d = S_IDLE;
            end else if (start_e) begin
               state_d = S_RUN;
               clr_d   = 1'b1;
            end else if (step_e) begin
               step_d = 1'b1;
            end
         end
         S_RUN: begin
            if (stop_e) begin
               state_d = S_PAUSE;
            end else if (hit_tc) begin
               state_d = S_DONE;
            end
         end
         S_PAUSE: begin
            if (stop_e) begin
               state_d = S_IDLE;
               clr_d   = 1'b1;
            end else if (start_e) begin
               state_d = S_RUN;
            end else if (hit_tc) begin
               state_d = S_DONE;
            end else if (step_e) begin
               step_d = 1'b1;
            end
         end
         S_DONE: begin
            if (stop_e) begin
               state_d = S_IDLE;
               clr_d   = 1'b1;
            end else if (start_e) begin
               state_d = S_RUN;
               clr_d   = 1'b1;
`ifdef COUNTER_SEQ_AUTO_RESTART_EN
            end else if (tick) begin
               state_d = S_RUN;
               clr_d   = 1'b1;
`endif
            end
         end
      endcase
   end

`ifdef COUNTER_SEQ_AUTO_RESTART_EN
   // Counting through the DONE-entry cycle makes the DONE tick land on its DIV-th cycle.
   assign tick_en = (state_q == S_RUN) || (state_d == S_DONE);
`else
   assign tick_en = (state_q == S_RUN);
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= S_IDLE;
         cmd_q      <= '0;
         cmd_prev_q <= '0;
         clr_q      <= 1'b0;
         step_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= {iStop, iStart, iStep};
         cmd_prev_q <= cmd_q;
         clr_q      <= clr_d;
         step_q     <= step_d;
         done_q     <= (state_d == S_DONE);
      end
   end

   seq_tick_gen #(
      .DIV(DIV)
   ) u_tick_gen (
      .CLK   (CLK),
      .RST   (RST),
      .iEn   (tick_en),
      .oTick (tick)
   );

   assign oEn    = en;
   assign oClr   = clr_q;
   assign oTick  = tick;
   assign oState = state_q;
   assign oDone  = done_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer with DIV=4, a behavioural counter datapath and a reference model.
module tb_counter_sequencer;
   import counter_seq_pkg::*;

   localparam int DIV   = DIV_BENCH;
   localparam int WIDTH = 3;
   localparam int TC    = 7;

   logic             clk    = 1'b0;
   logic             rst    = 1'b1;
   logic             iStart = 1'b0;
   logic             iStop  = 1'b0;
   logic             iStep  = 1'b0;
   logic             iMode  = 1'b0;
   logic [WIDTH-1:0] cnt    = '0;
   logic             oEn, oClr, oTick, oDone;
   logic [1:0]       oState;

   logic sampEn  = 1'b0;
   logic sampClr = 1'b0;
   logic chkOn   = 1'b0;

   int checkCount = 0;
   int passCount  = 0;

   // Reference model state: cycle index, phase bookkeeping and expected outputs.
   int         cyc = 0;
   int         mState = 0;
   int         mEntry = 0;
   int         mDoneEntry = 0;
   logic       expEn = 1'b0, expClr = 1'b0, expTick = 1'b0, expDone = 1'b0;
   logic [1:0] expState = 2'd0;
   logic [2:0] h1 = '0, h2 = '0;

   counter_sequencer #(
      .DIV   (DIV),
      .WIDTH (WIDTH),
      .TC    (TC)
   ) dut (
      .CLK    (clk),
      .RST    (rst),
      .iStart (iStart),
      .iStop  (iStop),
      .iStep  (iStep),
      .iMode  (iMode),
      .iQ     (cnt),
      .oEn    (oEn),
      .oClr   (oClr),
      .oTick  (oTick),
      .oState (oState),
      .oDone  (oDone)
   );

   always #5 clk = ~clk;

   // The counter datapath reacts to what the DUT drove during the cycle now ending.
   always @(negedge clk) begin
      sampEn  <= oEn;
      sampClr <= oClr;
   end

   // Reference model: states named by their codes, tick timing derived from cycles since RUN entry.
   always @(posedge clk or posedge rst) begin : refModel
      int   nState, nDoneEntry;
      logic nClr, nStep, nTick, stopE, startE, stepE, lastQ;
      if (rst) begin
         cyc <= 0; mState <= 0; mEntry <= 0; mDoneEntry <= 0;
         expEn <= 1'b0; expClr <= 1'b0; expTick <= 1'b0; expDone <= 1'b0; expState <= 2'd0;
         h1 <= '0; h2 <= '0; cnt <= '0;
      end else begin
         stopE  = h1[2] && !h2[2];
         startE = h1[1] && !h2[1];
         stepE  = h1[0] && !h2[0];
         lastQ  = (cnt == 3'(TC - 1));
         nState = mState;
         nClr   = 1'b0;
         nStep  = 1'b0;
         case (mState)
            0: begin
               if (!stopE && startE) begin nState = 1; nClr = 1'b1; end
               else if (!stopE && stepE) nStep = 1'b1;
            end
            1: begin
               if (stopE) nState = 2;
               else if (expEn && !iMode && lastQ) nState = 3;
            end
            2: begin
               if (stopE) begin nState = 0; nClr = 1'b1; end
               else if (startE) nState = 1;
               else if (expEn && !iMode && lastQ) nState = 3;
               else if (stepE) nStep = 1'b1;
            end
            default: begin
               if (stopE) begin nState = 0; nClr = 1'b1; end
               else if (startE) begin nState = 1; nClr = 1'b1; end
`ifdef COUNTER_SEQ_AUTO_RESTART_EN
               else if (cyc - mDoneEntry == DIV - 1) begin nState = 1; nClr = 1'b1; end
`endif
            end
         endcase
         nDoneEntry = (nState == 3 && mState != 3) ? cyc + 1 : mDoneEntry;
         nTick = (mState == 1) && ((cyc - mEntry) % DIV == DIV - 1);
`ifdef COUNTER_SEQ_AUTO_RESTART_EN
         if (nState == 3 && (cyc + 1 - nDoneEntry) == DIV - 1) nTick = 1'b1;
`endif
         mEntry     <= (nState == 1 && mState != 1) ? cyc + 1 : mEntry;
         mDoneEntry <= nDoneEntry;
         mState     <= nState;
         expClr     <= nClr;
         expTick    <= nTick;
         expEn      <= (nTick && nState == 1) || nStep;
         expDone    <= (nState == 3);
         expState   <= 2'(nState);
         if (sampClr) cnt <= '0;
         else if (sampEn) cnt <= cnt + 3'd1;
         h2  <= h1;
         h1  <= {iStop, iStart, iStep};
         cyc <= cyc + 1;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   task automatic timeoutFail(input string name);
      checkCount++;
      $display("[TB] FAIL %s: wait bound expired", name);
   endtask

   // Every cycle out of reset, every output is compared with the model.
   always @(negedge clk) begin
      if (chkOn && !rst) begin
         checkOutput("model_oState", 32'(oState), 32'(expState));
         checkOutput("model_oEn",    32'(oEn),    32'(expEn));
         checkOutput("model_oClr",   32'(oClr),   32'(expClr));
         checkOutput("model_oTick",  32'(oTick),  32'(expTick));
         checkOutput("model_oDone",  32'(oDone),  32'(expDone));
      end
   end

   task automatic applyStimulus(input logic start, input logic stop, input logic step, input int cycles);
      iStart = start;
      iStop  = stop;
      iStep  = step;
      repeat (cycles) @(negedge clk);
   endtask

   // One-cycle command pulse; returns at the negedge of the first cycle showing its effect.
   task automatic pulseCmd(input logic start, input logic stop, input logic step);
      applyStimulus(start, stop, step, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1);
   endtask

   task automatic waitState(input logic [1:0] target, input int budget, input string name);
      int n = 0;
      while (oState !== target && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (oState !== target) timeoutFail(name);
   endtask

   task automatic waitCnt(input logic [WIDTH-1:0] target, input int budget, input string name);
      int n = 0;
      while (cnt !== target && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (cnt !== target) timeoutFail(name);
   endtask

   task automatic countDone(input string name);
      int n = 0;
      while (oDone === 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      checkOutput({name, "_len"}, 32'(n), 32'(DIV));
      checkOutput({name, "_clr"}, 32'(oClr), 32'd1);
      checkOutput({name, "_state"}, 32'(oState), 32'd1);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [WIDTH-1:0] saved;
      int               enSeen;
      logic             sawDone;

      repeat (3) @(negedge clk);
      checkOutput("rst_oState", 32'(oState), 32'd0);
      checkOutput("rst_oEn",    32'(oEn),    32'd0);
      checkOutput("rst_oClr",   32'(oClr),   32'd0);
      checkOutput("rst_oTick",  32'(oTick),  32'd0);
      checkOutput("rst_oDone",  32'(oDone),  32'd0);
      rst   = 1'b0;
      chkOn = 1'b1;

      // Reset asserted in the middle of a run.
      iMode = 1'b0;
      pulseCmd(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 6);
      rst = 1'b1;
      #1;
      checkOutput("midrst_oState", 32'(oState), 32'd0);
      checkOutput("midrst_oEn",    32'(oEn),    32'd0);
      checkOutput("midrst_oClr",   32'(oClr),   32'd0);
      checkOutput("midrst_oTick",  32'(oTick),  32'd0);
      checkOutput("midrst_oDone",  32'(oDone),  32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // One-shot run to the terminal count.
      pulseCmd(1'b1, 1'b0, 1'b0);
      checkOutput("oneshot_clr",   32'(oClr),   32'd1);
      checkOutput("oneshot_state", 32'(oState), 32'd1);
      waitState(2'd3, 80, "oneshot_reach_done");
      checkOutput("oneshot_cnt", 32'(cnt), 32'd7);
      checkOutput("oneshot_done", 32'(oDone), 32'd1);
`ifdef COUNTER_SEQ_AUTO_RESTART_EN
      countDone("auto1");
      waitState(2'd3, 80, "auto_reach_done2");
      countDone("auto2");
`else
      applyStimulus(1'b0, 1'b0, 1'b0, 6);
      checkOutput("done_hold_cnt",   32'(cnt),    32'd7);
      checkOutput("done_hold_state", 32'(oState), 32'd3);
      pulseCmd(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 2);
      checkOutput("done_step_cnt",   32'(cnt),    32'd7);
      checkOutput("done_step_state", 32'(oState), 32'd3);
      pulseCmd(1'b1, 1'b0, 1'b0);
      checkOutput("done_start_clr",   32'(oClr),   32'd1);
      checkOutput("done_start_state", 32'(oState), 32'd1);
      @(negedge clk);
      checkOutput("done_start_cnt", 32'(cnt), 32'd0);
`endif
      pulseCmd(1'b0, 1'b1, 1'b0);
      checkOutput("stop1_state", 32'(oState), 32'd2);
      pulseCmd(1'b0, 1'b1, 1'b0);
      checkOutput("stop2_state", 32'(oState), 32'd0);
      checkOutput("stop2_clr",   32'(oClr),   32'd1);

      // Wrap mode: eight enables bring the counter back to zero.
      iMode = 1'b1;
      pulseCmd(1'b1, 1'b0, 1'b0);
      enSeen  = 0;
      sawDone = 1'b0;
      for (int i = 0; i < 60 && enSeen < 8; i++) begin
         @(negedge clk);
         if (oDone === 1'b1) sawDone = 1'b1;
         if (oEn === 1'b1) enSeen++;
      end
      if (enSeen < 8) timeoutFail("wrap_enables");
      @(negedge clk);
      checkOutput("wrap_cnt",     32'(cnt),     32'd0);
      checkOutput("wrap_state",   32'(oState),  32'd1);
      checkOutput("wrap_nodone",  32'(sawDone), 32'd0);

      // Pause at 3, single step, resume.
      iMode = 1'b0;
      waitCnt(3'd3, 40, "pause_reach3");
      pulseCmd(1'b0, 1'b1, 1'b0);
      checkOutput("pause_state", 32'(oState), 32'd2);
      applyStimulus(1'b0, 1'b0, 1'b0, 8);
      checkOutput("pause_cnt", 32'(cnt), 32'd3);
      pulseCmd(1'b0, 1'b0, 1'b1);
      checkOutput("pause_step_en", 32'(oEn), 32'd1);
      @(negedge clk);
      checkOutput("pause_step_cnt",   32'(cnt),    32'd4);
      checkOutput("pause_step_state", 32'(oState), 32'd2);
      pulseCmd(1'b1, 1'b0, 1'b0);
      checkOutput("resume_state", 32'(oState), 32'd1);
      checkOutput("resume_noclr", 32'(oClr),   32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 3);
      checkOutput("resume_tick_early", 32'(oTick), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1);
      checkOutput("resume_tick", 32'(oTick), 32'd1);
      checkOutput("resume_en",   32'(oEn),   32'd1);
      pulseCmd(1'b0, 1'b1, 1'b0);
      pulseCmd(1'b0, 1'b1, 1'b0);
      checkOutput("pause_stop_state", 32'(oState), 32'd0);
      checkOutput("pause_stop_clr",   32'(oClr),   32'd1);

      // Start and Stop together in IDLE: Stop wins.
      pulseCmd(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 3);
      checkOutput("collide_state", 32'(oState), 32'd0);

      // Stop arriving as the prescaler reaches its last count suppresses the enable.
      iMode = 1'b1;
      pulseCmd(1'b1, 1'b0, 1'b0);
      checkOutput("stoptick_run", 32'(oState), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 2);
      saved = cnt;
      applyStimulus(1'b0, 1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1);
      checkOutput("stoptick_en",    32'(oEn),    32'd0);
      checkOutput("stoptick_state", 32'(oState), 32'd2);
      @(negedge clk);
      checkOutput("stoptick_cnt", 32'(cnt), 32'(saved));
      pulseCmd(1'b0, 1'b1, 1'b0);
      checkOutput("stoptick_idle", 32'(oState), 32'd0);

      // Step from IDLE, then a held Step level that must act only once.
      @(negedge clk);
      saved = cnt;
      pulseCmd(1'b0, 1'b0, 1'b1);
      checkOutput("idle_step_en",    32'(oEn),    32'd1);
      checkOutput("idle_step_state", 32'(oState), 32'd0);
      @(negedge clk);
      checkOutput("idle_step_cnt", 32'(cnt), 32'(saved + 3'd1));
      saved = cnt;
      applyStimulus(1'b0, 1'b0, 1'b1, 6);
      applyStimulus(1'b0, 1'b0, 1'b0, 2);
      checkOutput("held_step_cnt", 32'(cnt), 32'(saved + 3'd1));

      applyStimulus(1'b0, 1'b0, 1'b0, 3);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
